// File: rtl/contactor_sequencer.sv
// Contactor sequencer: switches one contactor at a time from synchronized SPI requests.
// It verifies each switching event against router feedback, with a timeout and a settle gap.
module contactor_sequencer #(
    parameter int N_CONTACTORS      = 21,
    parameter int FB_TIMEOUT_CYCLES = 1000,
    parameter int SETTLE_CYCLES     = 100,
    parameter int CNT_W             = $clog2(((FB_TIMEOUT_CYCLES > SETTLE_CYCLES) ?
                                              FB_TIMEOUT_CYCLES : SETTLE_CYCLES) + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CONTACTORS-1:0]     spi_requests,
    input  logic [2*N_CONTACTORS-1:0]   router_feedback,
    input  logic                        shutdown_req,
    input  logic                        clear_errors,
    output logic [N_CONTACTORS-1:0]     contactor_drive,
    output logic [N_CONTACTORS-1:0]     contactor_status,
    output logic [N_CONTACTORS-1:0]     fault_mask,
    output logic                        feedback_timeout_error,
    output logic                        invalid_request,
    output logic                        busy
);

    localparam int IDX_W = (N_CONTACTORS > 1) ? $clog2(N_CONTACTORS) : 1;
    localparam logic [CNT_W-1:0] FB_LAST     = CNT_W'(FB_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_FB = 2'd1,
        ST_SETTLE  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [N_CONTACTORS-1:0]   drive_q, drive_d;
    logic [N_CONTACTORS-1:0]   mask_q, mask_d;
    logic [N_CONTACTORS-1:0]   status_q, status_d;
    logic [N_CONTACTORS-1:0]   meta_q, meta_d;
    logic [N_CONTACTORS-1:0]   req_sync_q, req_sync_d;
    logic                      tout_q, tout_d;
    logic                      inval_q, inval_d;

    logic [N_CONTACTORS-1:0]   pending;
    logic [IDX_W-1:0]          pick;
    logic [1:0]                fb_sel;
    logic [1:0]                fb_want;

    assign pending = (req_sync_q ^ drive_q) & ~mask_q & {N_CONTACTORS{~shutdown_req}};
    assign fb_sel  = router_feedback[{idx_q, 1'b0} +: 2];
    assign fb_want = drive_q[idx_q] ? 2'b10 : 2'b01;

    // Downward scan so the lowest pending index is the one left standing.
    always_comb begin
        pick = '0;
        for (int i = N_CONTACTORS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pick = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        drive_d    = drive_q;
        mask_d     = mask_q;
        tout_d     = tout_q;
        inval_d    = inval_q;
        meta_d     = spi_requests;
        req_sync_d = meta_q;
        for (int i = 0; i < N_CONTACTORS; i++) begin
            status_d[i] = (router_feedback[2*i +: 2] == 2'b10);
        end

        // Clear first so that a coincident timeout or invalid condition wins.
        if (clear_errors) begin
            mask_d  = '0;
            tout_d  = 1'b0;
            inval_d = 1'b0;
        end

        if (shutdown_req) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            drive_d = '0;
            if (|req_sync_q) begin
                inval_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|pending) begin
                        idx_d          = pick;
                        drive_d[pick]  = ~drive_q[pick];
                        cnt_d          = '0;
                        state_d        = ST_WAIT_FB;
                    end
                end
                ST_WAIT_FB: begin
                    if (fb_sel == fb_want) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q == FB_LAST) begin
                        drive_d[idx_q] = 1'b0;
                        mask_d[idx_q]  = 1'b1;
                        tout_d         = 1'b1;
                        state_d        = ST_SETTLE;
                        cnt_d          = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q >= SETTLE_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            drive_q    <= '0;
            mask_q     <= '0;
            status_q   <= '0;
            meta_q     <= '0;
            req_sync_q <= '0;
            tout_q     <= 1'b0;
            inval_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            drive_q    <= drive_d;
            mask_q     <= mask_d;
            status_q   <= status_d;
            meta_q     <= meta_d;
            req_sync_q <= req_sync_d;
            tout_q     <= tout_d;
            inval_q    <= inval_d;
        end
    end

    assign contactor_drive        = drive_q;
    assign contactor_status       = status_q;
    assign fault_mask             = mask_q;
    assign feedback_timeout_error = tout_q;
    assign invalid_request        = inval_q;
    assign busy                   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_contactor_sequencer.sv
// Randomized bench for contactor_sequencer: an event/timestamp reference model
// predicts every output each cycle; a lagging or stuck router model answers the drive.
module tb_contactor_sequencer;

    localparam int N  = 21;
    localparam int T  = 20;
    localparam int S  = 5;
    localparam int SP = (S == 0) ? 1 : S;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     spi_requests;
    logic [2*N-1:0]   router_feedback;
    logic             shutdown_req;
    logic             clear_errors;
    logic [N-1:0]     contactor_drive;
    logic [N-1:0]     contactor_status;
    logic [N-1:0]     fault_mask;
    logic             feedback_timeout_error;
    logic             invalid_request;
    logic             busy;

    contactor_sequencer #(
        .N_CONTACTORS      (N),
        .FB_TIMEOUT_CYCLES (T),
        .SETTLE_CYCLES     (S)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .spi_requests           (spi_requests),
        .router_feedback        (router_feedback),
        .shutdown_req           (shutdown_req),
        .clear_errors           (clear_errors),
        .contactor_drive        (contactor_drive),
        .contactor_status       (contactor_status),
        .fault_mask             (fault_mask),
        .feedback_timeout_error (feedback_timeout_error),
        .invalid_request        (invalid_request),
        .busy                   (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: an event is a toggle time plus a known end age.
    logic [N-1:0] m_s1, m_s2, m_drive, m_mask, m_status;
    logic         m_tout, m_inval;
    int           m_evt, m_age, m_end;

    // Router model
    logic [N-1:0] hist [4];
    int           lag [N];
    logic [N-1:0] stuck;
    logic [1:0]   stuck_val [N];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [N-1:0] s2_old;
        logic [N-1:0] mask_old;
        logic [1:0]   want;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_drive = '0; m_mask = '0; m_status = '0;
            m_tout = 1'b0; m_inval = 1'b0; m_evt = -1; m_age = 0; m_end = -1;
        end else begin
            s2_old   = m_s2;
            mask_old = m_mask;
            for (int i = 0; i < N; i++) m_status[i] = (router_feedback[2*i +: 2] == 2'b10);
            m_s2 = m_s1;
            m_s1 = spi_requests;
            if (clear_errors) begin
                m_mask = '0; m_tout = 1'b0; m_inval = 1'b0;
            end
            if (shutdown_req) begin
                m_drive = '0;
                m_evt   = -1;
                if (|s2_old) m_inval = 1'b1;
            end else if (m_evt < 0) begin
                for (int i = 0; i < N; i++) begin
                    if (s2_old[i] != m_drive[i] && !mask_old[i]) begin
                        m_drive[i] = ~m_drive[i];
                        m_evt = i; m_age = 0; m_end = -1;
                        break;
                    end
                end
            end else begin
                if (m_end < 0) begin
                    want = m_drive[m_evt] ? 2'b10 : 2'b01;
                    if (router_feedback[2*m_evt +: 2] == want) begin
                        m_end = m_age + SP;
                    end else if (m_age == T - 1) begin
                        m_drive[m_evt] = 1'b0;
                        m_mask[m_evt]  = 1'b1;
                        m_tout         = 1'b1;
                        m_end          = m_age + SP;
                    end
                end else if (m_age == m_end) begin
                    m_evt = -1;
                end
                m_age++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_val("drive",  32'(contactor_drive),  32'(m_drive));
        check_val("status", 32'(contactor_status), 32'(m_status));
        check_val("mask",   32'(fault_mask),       32'(m_mask));
        check_val("tout",   32'(feedback_timeout_error), 32'(m_tout));
        check_val("inval",  32'(invalid_request),  32'(m_inval));
        check_val("busy",   32'(busy),             32'(m_evt >= 0));
        hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = m_drive;
        for (int i = 0; i < N; i++) begin
            if (stuck[i]) router_feedback[2*i +: 2] = stuck_val[i];
            else          router_feedback[2*i +: 2] = hist[lag[i]][i] ? 2'b10 : 2'b01;
        end
    endtask

    logic [N-1:0] req_tab [4];

    initial begin
        int           len, mode, rst_at, sd_left, b;
        logic [N-1:0] req;
        req_tab[0] = 21'h000004;
        req_tab[1] = 21'h000085;
        req_tab[2] = 21'h0000A5;
        req_tab[3] = 21'h000008;
        for (int k = 0; k < 4; k++) hist[k] = '0;
        for (int i = 0; i < N; i++) begin lag[i] = 0; stuck_val[i] = 2'b01; end
        stuck = '0;
        rst = 1'b1; spi_requests = '0; shutdown_req = 1'b0; clear_errors = 1'b0;
        router_feedback = {N{2'b01}};
        m_evt = -1;
        repeat (3) step();
        rst = 1'b0;
        req = '0;
        for (int tr = 0; tr < 40; tr++) begin
            mode = tr % 4;
            if (tr < 4) begin
                req = req_tab[tr];
            end else begin
                for (int k = 0; k < 3; k++) req[$urandom_range(N - 1, 0)] ^= 1'b1;
            end
            stuck = '0;
            if (tr == 1) begin
                for (int i = 0; i < N; i++) lag[i] = 0;
            end else begin
                for (int i = 0; i < N; i++) lag[i] = $urandom_range(3, 0);
            end
            if (tr == 2 || tr >= 4 && ($urandom_range(1, 0) == 1)) begin
                b = (tr == 2) ? 5 : $urandom_range(N - 1, 0);
                stuck[b] = 1'b1;
                stuck_val[b] = ($urandom_range(2, 0) == 0) ? 2'b11 : 2'b01;
            end
            len    = $urandom_range(200, 60);
            rst_at = (mode == 0 && tr > 0) ? $urandom_range(len - 1, 10) : -1;
            sd_left = 0;
            $display("txn %0d mode %0d req %06h stuck %06h len %0d", tr, mode, req, stuck, len);
            for (int c = 0; c < len; c++) begin
                spi_requests = req;
                rst = (c == rst_at);
                case (mode)
                    1: clear_errors = ($urandom_range(7, 0) == 0);
                    2: begin
                        if (sd_left == 0 && $urandom_range(39, 0) == 0) sd_left = $urandom_range(10, 1);
                        shutdown_req = (sd_left > 0);
                        if (sd_left > 0) sd_left--;
                        clear_errors = (c == len - 1);
                    end
                    3: clear_errors = 1'b1;
                    default: clear_errors = 1'b0;
                endcase
                step();
            end
            rst = 1'b0; shutdown_req = 1'b0; clear_errors = 1'b0;
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
